// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin arbiter sharing one two-stage single-precision multiplier
// among N_REQ requesters, with a one-entry result buffer per requester.
//
// Ports:
//   clk        - clock, rising edge
//   rstn       - asynchronous active-low reset
//   req_valid  - [N_REQ] requester i has an operation
//   req_ready  - [N_REQ] one-hot grant (or zero); combinational on req_valid/rsp_ready
//   req_x1     - [32*N_REQ] operand 1, slice [32i+31:32i] per requester (must be normalized)
//   req_x2     - [32*N_REQ] operand 2, same slicing
//   rsp_valid  - [N_REQ] result buffer i is full
//   rsp_ready  - [N_REQ] requester i consumes its result
//   rsp_y      - [32*N_REQ] result buffer contents, same slicing
//
// Multiplier: truncating product, zero/subnormal exponent on either operand yields signed
// zero, exponent overflow yields signed infinity, underflow flushes to signed zero.
module fmul_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_x1,
    input  logic [32*N_REQ-1:0]  req_x2,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [32*N_REQ-1:0]  rsp_y
);

    logic                inflight_v_q;
    logic [ID_W-1:0]     inflight_id_q;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]    rsp_valid_q;
    logic [32*N_REQ-1:0] rsp_y_q;

    logic [N_REQ-1:0]    elig;
    logic                gnt_v;
    logic [ID_W-1:0]     gnt_id;
    logic                issue;
    logic [31:0]         x1, x2;

    // Multiplier stage register (deliberately not reset; its output is only used
    // when inflight_v_q is set).
    logic                st_sign;
    logic                st_zero;
    logic [9:0]          st_exp;
    logic [47:0]         st_prod;
    logic [31:0]         fmul_y;

    // ---------------- Arbitration ----------------
    always_comb begin
        int idx;
        elig   = '0;
        gnt_v  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i]
                    & ~(inflight_v_q & (inflight_id_q == ID_W'(i)))
                    & (~rsp_valid_q[i] | rsp_ready[i]);
        end
        // Search ptr, ptr+1, ... wrapping explicitly so non-power-of-two N_REQ works.
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!gnt_v && elig[idx]) begin
                gnt_v  = 1'b1;
                gnt_id = ID_W'(idx);
            end
        end
    end

    assign issue = gnt_v & rstn;

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[gnt_id] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
    end

    // Operands of the granted requester; zero on idle cycles.
    always_comb begin
        x1 = '0;
        x2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (issue && gnt_id == ID_W'(i)) begin
                x1 = req_x1[32*i +: 32];
                x2 = req_x2[32*i +: 32];
            end
        end
    end

    // ---------------- Multiplier ----------------
    always_ff @(posedge clk) begin
        st_sign <= x1[31] ^ x2[31];
        st_zero <= (x1[30:23] == 8'd0) | (x2[30:23] == 8'd0);
        // Biased exponent sum minus bias; bit 9 acts as sign (range -127..383).
        st_exp  <= {2'b00, x1[30:23]} + {2'b00, x2[30:23]} - 10'd127;
        st_prod <= {24'd0, 1'b1, x1[22:0]} * {24'd0, 1'b1, x2[22:0]};
    end

    always_comb begin
        logic [9:0]  e_norm;
        logic [22:0] mant;
        e_norm = st_exp + {9'd0, st_prod[47]};
        mant   = st_prod[47] ? st_prod[46:24] : st_prod[45:23];
        if (st_zero || e_norm[9] || e_norm == 10'd0) begin
            fmul_y = {st_sign, 31'd0};
        end else if (e_norm >= 10'd255) begin
            fmul_y = {st_sign, 8'hFF, 23'd0};
        end else begin
            fmul_y = {st_sign, e_norm[7:0], mant};
        end
    end

    // ---------------- State ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_v_q  <= 1'b0;
            inflight_id_q <= '0;
            ptr_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_y_q       <= '0;
        end else begin
            inflight_v_q <= issue;
            ptr_q        <= ptr_d;
            if (issue) inflight_id_q <= gnt_id;
            for (int i = 0; i < N_REQ; i++) begin
                // Retire wins over a same-cycle consume.
                if (inflight_v_q && inflight_id_q == ID_W'(i)) begin
                    rsp_valid_q[i]      <= 1'b1;
                    rsp_y_q[32*i +: 32] <= fmul_y;
                end else if (rsp_valid_q[i] && rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;

endmodule
